// File: rtl/hold_bank.sv
// hold_bank: multi-slot tetromino hold store with swap or FIFO-rotate modes and per-piece lockout
module hold_bank #(
  parameter int NUM_SLOTS = 2,
  parameter int IDX_W = 3,
  parameter logic [IDX_W-1:0] EMPTY_IDX = IDX_W'(7),
  parameter int MODE = 0,
  parameter int LOCKOUT_EN = 1,
  localparam int SEL_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int OCC_W = $clog2(NUM_SLOTS + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_clear,
  input  logic                       i_hold_req,
  input  logic [SEL_W-1:0]           i_slot_sel,
  input  logic [IDX_W-1:0]           i_curr_idx,
  input  logic                       i_piece_locked,
  output logic                       o_busy,
  output logic                       o_resp_valid,
  output logic [IDX_W-1:0]           o_resp_idx,
  output logic                       o_resp_fetch,
  output logic                       o_rejected,
  output logic                       o_hold_used,
  output logic [OCC_W-1:0]           o_occupancy,
  output logic [NUM_SLOTS*IDX_W-1:0] o_slots_flat
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t r_state, w_next;
  logic [IDX_W-1:0] r_slots [NUM_SLOTS];
  logic [IDX_W-1:0] r_cur, r_resp_idx;
  logic [SEL_W-1:0] r_sel;
  logic r_hold_used, r_rejected, r_resp_fetch;
  logic [OCC_W-1:0] w_occ;
  logic w_req, w_bad, w_accept;
  always_comb begin
    w_occ = '0;
    for (int i = 0; i < NUM_SLOTS; i++) w_occ = w_occ + OCC_W'(r_slots[i] != EMPTY_IDX);
  end
  // a placed piece in the same cycle swallows the request entirely
  assign w_req = (r_state == IDLE) && i_hold_req && !i_piece_locked;
  assign w_bad = ((LOCKOUT_EN != 0) && r_hold_used) || (i_curr_idx == EMPTY_IDX) ||
                 ((MODE == 0) && (int'(i_slot_sel) >= NUM_SLOTS));
  assign w_accept = w_req && !w_bad;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (w_accept ? EXEC : IDLE) : (r_state == EXEC) ? RESP : IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      for (int i = 0; i < NUM_SLOTS; i++) r_slots[i] <= EMPTY_IDX;
      r_cur <= EMPTY_IDX;
      r_sel <= '0;
      r_resp_idx <= EMPTY_IDX;
      r_resp_fetch <= 1'b0;
      r_hold_used <= 1'b0;
      r_rejected <= 1'b0;
    end else if (i_clear) begin
      r_state <= IDLE;
      for (int i = 0; i < NUM_SLOTS; i++) r_slots[i] <= EMPTY_IDX;
      r_hold_used <= 1'b0;
      r_rejected <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rejected <= w_req && w_bad;
      if (w_accept) begin
        r_cur <= i_curr_idx;
        r_sel <= i_slot_sel;
      end
      if (r_state == EXEC) begin
        if (MODE == 0) begin
          r_resp_idx <= r_slots[r_sel];
          r_resp_fetch <= (r_slots[r_sel] == EMPTY_IDX);
          r_slots[r_sel] <= r_cur;
        end else if (int'(w_occ) < NUM_SLOTS) begin
          r_slots[SEL_W'(w_occ)] <= r_cur;
          r_resp_idx <= EMPTY_IDX;
          r_resp_fetch <= 1'b1;
        end else begin
          r_resp_idx <= r_slots[0];
          r_resp_fetch <= 1'b0;
          for (int i = 0; i < NUM_SLOTS - 1; i++) r_slots[i] <= r_slots[i+1];
          r_slots[NUM_SLOTS-1] <= r_cur;
        end
      end
      r_hold_used <= i_piece_locked ? 1'b0 : ((r_state == EXEC) ? 1'b1 : r_hold_used);
    end
  end
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_flat
    assign o_slots_flat[g*IDX_W +: IDX_W] = r_slots[g];
  end
  assign o_busy = (r_state != IDLE);
  assign o_resp_valid = (r_state == RESP);
  assign o_resp_idx = r_resp_idx;
  assign o_resp_fetch = r_resp_fetch;
  assign o_rejected = r_rejected;
  assign o_hold_used = r_hold_used;
  assign o_occupancy = w_occ;
endmodule
